// File: rtl/racetrack_pkg.sv
// rtl/racetrack_pkg.sv - shared types, constants and domain-index helper for the racetrack port controller
package racetrack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_e;

  localparam logic SHIFT_UP   = 1'b1;
  localparam logic SHIFT_DOWN = 1'b0;

  // Word index of a byte address, wrapped to the number of domains on the track.
  function automatic logic [31:0] domain_index(input logic [31:0] addr, input int unsigned pos_bits);
    return (addr >> 2) & ((32'd1 << pos_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/racetrack_rr_arbiter.sv
// rtl/racetrack_rr_arbiter.sv - 2-way round-robin arbiter between instruction and data requesters
module racetrack_rr_arbiter
  import racetrack_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_instr,
  input  logic req_data,
  input  logic update,
  output logic gnt_instr,
  output logic gnt_data,
  output req_e winner
);

  req_e last_q;

  always_comb begin
    winner = REQ_INSTR;
    if (req_instr && req_data) begin
      // On conflict the side that did not win last time gets the port.
      winner = (last_q == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
    end else if (req_data) begin
      winner = REQ_DATA;
    end
  end

  assign gnt_instr = req_instr && (winner == REQ_INSTR);
  assign gnt_data  = req_data  && (winner == REQ_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_INSTR;
    end else if (update) begin
      last_q <= winner;
    end
  end

endmodule

// File: rtl/racetrack_port_ctrl.sv
// rtl/racetrack_port_ctrl.sv - shares one racetrack port between fetch and data, aligning the head before each access
// Optional statistics counters are built when RT_SHIFT_STATS_EN is defined.
module racetrack_port_ctrl
  import racetrack_pkg::*;
#(
  parameter int ADDR_WIDTH   = 22,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_DOMAINS  = 64,
  parameter int SHIFT_CYCLES = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    shift_en_o,
  output logic                    shift_dir_o,
  output logic [31:0]             shift_cnt_o,
  output logic [31:0]             access_cnt_o
);

  localparam int POS_W = $clog2(NUM_DOMAINS);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int SUB_W = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SHIFT_CYCLES - 1);

  state_e                  state_q;
  req_e                    owner_q;
  logic [POS_W-1:0]        pos_q;
  logic [POS_W-1:0]        tgt_q;
  logic                    dir_q;
  logic [SUB_W-1:0]        sub_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [BE_W-1:0]         be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic                    idle;
  logic                    grant;
  logic                    arb_gnt_instr;
  logic                    arb_gnt_data;
  req_e                    winner;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [POS_W-1:0]        win_tgt;
  logic [POS_W-1:0]        pos_step;
  logic                    step_done;

  assign idle  = (state_q == ST_IDLE);
  assign grant = idle && (instr_req_i || data_req_i);

  racetrack_rr_arbiter u_arb (
    .clk       (clk_i),
    .rst       (rst_i),
    .req_instr (instr_req_i),
    .req_data  (data_req_i),
    .update    (grant),
    .gnt_instr (arb_gnt_instr),
    .gnt_data  (arb_gnt_data),
    .winner    (winner)
  );

  assign win_addr  = (winner == REQ_DATA) ? data_addr_i : instr_addr_i;
  assign win_tgt   = POS_W'(domain_index(32'(win_addr), POS_W));
  assign pos_step  = (dir_q == SHIFT_UP) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
  assign step_done = (state_q == ST_SHIFT) && (sub_q == SUB_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_INSTR;
      pos_q   <= '0;
      tgt_q   <= '0;
      dir_q   <= SHIFT_DOWN;
      sub_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (grant) begin
            owner_q <= winner;
            addr_q  <= win_addr;
            we_q    <= (winner == REQ_DATA) && data_we_i;
            be_q    <= (winner == REQ_DATA) ? data_be_i : '1;
            wdata_q <= (winner == REQ_DATA) ? data_wdata_i : '0;
            tgt_q   <= win_tgt;
            dir_q   <= (win_tgt > pos_q) ? SHIFT_UP : SHIFT_DOWN;
            sub_q   <= '0;
            state_q <= (win_tgt != pos_q) ? ST_SHIFT : ST_ACCESS;
          end
        end
        ST_SHIFT: begin
          if (sub_q == SUB_LAST) begin
            sub_q <= '0;
            pos_q <= pos_step;
            if (pos_step == tgt_q) begin
              state_q <= ST_ACCESS;
            end
          end else begin
            sub_q <= sub_q + SUB_W'(1);
          end
        end
        ST_ACCESS: state_q <= ST_RESP;
        ST_RESP:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_gnt_o    = idle && arb_gnt_instr;
  assign data_gnt_o     = idle && arb_gnt_data;
  assign shift_en_o     = (state_q == ST_SHIFT);
  assign shift_dir_o    = dir_q;
  assign mem_req_o      = (state_q == ST_ACCESS);
  assign mem_addr_o     = addr_q;
  assign mem_we_o       = we_q;
  assign mem_be_o       = be_q;
  assign mem_wdata_o    = wdata_q;
  assign instr_rvalid_o = (state_q == ST_RESP) && (owner_q == REQ_INSTR);
  assign data_rvalid_o  = (state_q == ST_RESP) && (owner_q == REQ_DATA);
  // Read data is only exposed during the owner's response beat.
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;

`ifdef RT_SHIFT_STATS_EN
  logic [31:0] shift_cnt_q;
  logic [31:0] access_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_cnt_q  <= '0;
      access_cnt_q <= '0;
    end else begin
      if (step_done) shift_cnt_q <= shift_cnt_q + 32'd1;
      if (mem_req_o) access_cnt_q <= access_cnt_q + 32'd1;
    end
  end

  assign shift_cnt_o  = shift_cnt_q;
  assign access_cnt_o = access_cnt_q;
`else
  logic unused_step_done;
  assign unused_step_done = step_done;
  assign shift_cnt_o  = '0;
  assign access_cnt_o = '0;
`endif

endmodule

// File: tb/tb_racetrack_port_ctrl.sv
// tb/tb_racetrack_port_ctrl.sv - self-checking bench for racetrack_port_ctrl (64 domains, one cycle per shift)
module tb_racetrack_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req = 1'b0, instr_gnt, instr_rvalid;
  logic [21:0] instr_addr = '0;
  logic [31:0] instr_rdata;
  logic        data_req = 1'b0, data_gnt, data_we = 1'b0, data_rvalid;
  logic [21:0] data_addr = '0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_wdata = '0, data_rdata;
  logic        mem_req, mem_we, shift_en, shift_dir;
  logic [21:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata = '0, shift_cnt, access_cnt;

  racetrack_port_ctrl #(.ADDR_WIDTH(22), .DATA_WIDTH(32), .NUM_DOMAINS(64), .SHIFT_CYCLES(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_addr_i(instr_addr),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_addr_i(data_addr),
    .data_we_i(data_we), .data_be_i(data_be), .data_wdata_i(data_wdata),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .shift_en_o(shift_en), .shift_dir_o(shift_dir),
    .shift_cnt_o(shift_cnt), .access_cnt_o(access_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    logic [21:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          d;
    bit          dir;
    string       name;
  } vec_t;

  typedef struct {
    bit          is_data;
    bit          chk;
    logic [31:0] rdata;
    int          g;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  vec_t        vecs[7];
  logic [31:0] arr[256];
  logic [31:0] ref_mem[256];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          model_pos = 0;
  int          g0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural racetrack array: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_req) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_be[b]) arr[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= arr[mem_addr[9:2]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_data, input logic [21:0] addr, input bit we,
                          input logic [3:0] be, input logic [31:0] wdata);
    exp_t e;
    int tgt;
    tgt = int'(addr[7:2]);
    e.is_data = is_data;
    e.chk = !we;
    e.rdata = ref_mem[addr[9:2]];
    e.g = cyc;
    e.lat = ((tgt > model_pos) ? tgt - model_pos : model_pos - tgt) + 2;
    model_pos = tgt;
    if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[addr[9:2]][b*8 +: 8] = wdata[b*8 +: 8];
    exp_q.push_back(e);
  endtask

  // Scoreboard: every response beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (instr_rvalid || data_rvalid) begin
      if (exp_q.size() == 0) begin
        check("spurious_rvalid", {instr_rvalid, data_rvalid}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("rvalid_owner", {instr_rvalid, data_rvalid}, e.is_data ? 2'b01 : 2'b10);
        check("rvalid_latency", cyc - e.g, e.lat);
        if (e.chk) check("rdata", e.is_data ? data_rdata : instr_rdata, e.rdata);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {instr_gnt, data_gnt, instr_rvalid, data_rvalid, mem_req, shift_en, shift_dir}, 0);
    check({tag, "_rdata"}, {instr_rdata, data_rdata}, 0);
    check({tag, "_mem"}, {mem_addr, mem_we, mem_be, mem_wdata}, 0);
    check({tag, "_cnt"}, {shift_cnt, access_cnt}, 0);
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst = 1'b1; instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    @(negedge clk);
    exp_q.delete();
    model_pos = 0;
    if (chk) check_zero("reset");
    rst = 1'b0;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      #1;
      if (instr_gnt || data_gnt) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic run_txn(input vec_t v);
    bit ok;
    int shifts, memc, dir_bad;
    @(negedge clk);
    if (v.is_data) begin
      data_req = 1'b1; data_addr = v.addr; data_we = v.we; data_be = v.be; data_wdata = v.wdata;
    end else begin
      instr_req = 1'b1; instr_addr = v.addr;
    end
    wait_gnt(ok);
    check({v.name, "_gnt"}, ok && (v.is_data ? data_gnt : instr_gnt), 1);
    g0 = cyc;
    push_exp(v.is_data, v.addr, v.we, v.be, v.wdata);
    @(negedge clk);
    instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    shifts = 0; memc = -1; dir_bad = 0; ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (shift_en) begin
        shifts++;
        if (shift_dir !== v.dir) dir_bad++;
      end
      if (mem_req) begin
        memc = cyc - g0;
        check({v.name, "_mem_addr"}, mem_addr, v.addr);
        check({v.name, "_mem_we"}, mem_we, v.we);
        if (v.we) check({v.name, "_mem_be_wdata"}, {mem_be, mem_wdata}, {v.be, v.wdata});
      end
      if (v.is_data ? data_rvalid : instr_rvalid) ok = 1'b1;
      else @(negedge clk);
    end
    check({v.name, "_shifts"}, shifts, v.d);
    check({v.name, "_mem_req_cycle"}, memc, v.d + 1);
    check({v.name, "_rvalid_seen"}, ok, 1);
    if (v.d > 0) check({v.name, "_dir"}, dir_bad, 0);
  endtask

  initial begin
    bit ok;
    int shifts;
    for (int i = 0; i < 256; i++) begin
      arr[i] = 32'hA5A5_0000 | i;
      ref_mem[i] = 32'hA5A5_0000 | i;
    end
    vecs[0] = '{1'b0, 22'h000, 1'b0, 4'hF, 32'h0,         0,  1'b0, "s1_instr_000"};
    vecs[1] = '{1'b1, 22'h040, 1'b0, 4'hF, 32'h0,         16, 1'b1, "s2_data_040"};
    vecs[2] = '{1'b0, 22'h010, 1'b0, 4'hF, 32'h0,         12, 1'b0, "s3_instr_010"};
    vecs[3] = '{1'b1, 22'h100, 1'b1, 4'h3, 32'hDEAD_BEEF, 4,  1'b0, "s3_data_wr_100"};
    vecs[4] = '{1'b1, 22'h0FC, 1'b0, 4'hF, 32'h0,         63, 1'b1, "edge_data_0fc"};
    vecs[5] = '{1'b0, 22'h0FC, 1'b0, 4'hF, 32'h0,         0,  1'b0, "edge_instr_0fc"};
    vecs[6] = '{1'b0, 22'h100, 1'b0, 4'hF, 32'h0,         63, 1'b0, "edge_instr_100"};

    do_reset(1'b1);
    for (int i = 0; i < 4; i++) run_txn(vecs[i]);
`ifdef RT_SHIFT_STATS_EN
    check("stats_shift_cnt", shift_cnt, 32);
    check("stats_access_cnt", access_cnt, 4);
`else
    check("stats_shift_cnt", shift_cnt, 0);
    check("stats_access_cnt", access_cnt, 0);
`endif
    for (int i = 4; i < 7; i++) run_txn(vecs[i]);

    // Arbitration: first conflict after reset goes to data, a repeat conflict to instr.
    do_reset(1'b0);
    @(negedge clk);
    instr_req = 1'b1; instr_addr = 22'h000;
    data_req = 1'b1; data_addr = 22'h008; data_we = 1'b0;
    wait_gnt(ok);
    check("arb_first_data", {instr_gnt, data_gnt}, 2'b01);
    push_exp(1'b1, 22'h008, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    data_addr = 22'h00C;
    wait_gnt(ok);
    check("arb_repeat_instr", {instr_gnt, data_gnt}, 2'b10);
    push_exp(1'b0, 22'h000, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    instr_req = 1'b0;
    wait_gnt(ok);
    check("arb_then_data", {instr_gnt, data_gnt}, 2'b01);
    push_exp(1'b1, 22'h00C, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    data_req = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check("arb_drain", exp_q.size(), 0);

    // Reset in the 8th cycle of a 16-domain shift.
    do_reset(1'b0);
    @(negedge clk);
    data_req = 1'b1; data_addr = 22'h040; data_we = 1'b0;
    wait_gnt(ok);
    check("mid_rst_gnt", data_gnt, 1);
    push_exp(1'b1, 22'h040, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    data_req = 1'b0;
    shifts = 0;
    for (int i = 0; i < 40 && shifts < 8; i++) begin
      if (shift_en) shifts++;
      if (shifts < 8) @(negedge clk);
    end
    check("mid_rst_shift8", shifts, 8);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b0;
    model_pos = 0;
    repeat (5) @(negedge clk);
    run_txn(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
